// File: rtl/raster_pkg.sv
// Shared types for the triangle command path: coordinates,
// vertices, triangles, sequencer states and the stable y-sort.
package raster_pkg;

  localparam int COORD_BITS = 9;

  typedef logic [COORD_BITS-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } vertex_t;

  typedef struct packed {
    vertex_t v1;
    vertex_t v2;
    vertex_t v3;
  } triangle_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SORT,
    S_LAUNCH,
    S_WAIT,
    S_RETIRE
  } seq_state_t;

  // Three-stage bubble network; strict compares keep ties in
  // command order, which makes the sort stable.
  function automatic triangle_t sort_by_y(triangle_t t);
    vertex_t a;
    vertex_t b;
    vertex_t c;
    vertex_t tmp;
    triangle_t r;
    a = t.v1;
    b = t.v2;
    c = t.v3;
    if (a.y > b.y) begin
      tmp = a;
      a   = b;
      b   = tmp;
    end
    if (b.y > c.y) begin
      tmp = b;
      b   = c;
      c   = tmp;
    end
    if (a.y > b.y) begin
      tmp = a;
      a   = b;
      b   = tmp;
    end
    r.v1 = a;
    r.v2 = b;
    r.v3 = c;
    return r;
  endfunction

endpackage

// File: rtl/tri_cmd_fifo.sv
// Command queue ahead of the sequencer: read/write pointers plus
// an occupancy count, no bypass from push to pop.
module tri_cmd_fifo
  import raster_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = triangle_t
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  T     din,
  output T     dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  T              mem_q [DEPTH];
  logic [AW-1:0] rd_q;
  logic [AW-1:0] wr_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign dout    = mem_q[rd_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage array; contents need no reset, the count guards reads.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

  // Pointers wrap naturally at DEPTH, a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/triangle_sequencer.sv
// Queues triangle commands, y-sorts them, launches the shared
// filler and counts completed and dropped triangles.
module triangle_sequencer
  import raster_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4,
  parameter int COORD_W     = COORD_BITS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COORD_W-1:0] cmd_x1,
  input  logic [COORD_W-1:0] cmd_y1,
  input  logic [COORD_W-1:0] cmd_x2,
  input  logic [COORD_W-1:0] cmd_y2,
  input  logic [COORD_W-1:0] cmd_x3,
  input  logic [COORD_W-1:0] cmd_y3,
  output logic [COORD_W-1:0] fill_x1,
  output logic [COORD_W-1:0] fill_y1,
  output logic [COORD_W-1:0] fill_x2,
  output logic [COORD_W-1:0] fill_y2,
  output logic [COORD_W-1:0] fill_x3,
  output logic [COORD_W-1:0] fill_y3,
  output logic               fill_start,
  input  logic               fill_done,
  output logic               busy,
  output logic [15:0]        tri_done_count,
  output logic [15:0]        tri_skip_count
);

  seq_state_t state_q, state_d;
  triangle_t  tri_q, tri_d;
  triangle_t  fill_q, fill_d;
  triangle_t  cmd_tri;
  triangle_t  head;
  triangle_t  sorted;
  logic       guard_q, guard_d;
  logic [15:0] done_q, done_d;
  logic [15:0] skip_q, skip_d;
  logic       full;
  logic       empty;
  logic       pop;
  logic       push;

  assign cmd_tri.v1.x = cmd_x1;
  assign cmd_tri.v1.y = cmd_y1;
  assign cmd_tri.v2.x = cmd_x2;
  assign cmd_tri.v2.y = cmd_y2;
  assign cmd_tri.v3.x = cmd_x3;
  assign cmd_tri.v3.y = cmd_y3;

  assign cmd_ready = !full && !reset;
  assign push      = cmd_valid && cmd_ready;

  tri_cmd_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .T     (triangle_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (cmd_tri),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign sorted = sort_by_y(tri_q);

  assign fill_x1 = fill_q.v1.x;
  assign fill_y1 = fill_q.v1.y;
  assign fill_x2 = fill_q.v2.x;
  assign fill_y2 = fill_q.v2.y;
  assign fill_x3 = fill_q.v3.x;
  assign fill_y3 = fill_q.v3.y;

  assign fill_start     = (state_q == S_LAUNCH);
  assign busy           = !empty || (state_q != S_IDLE);
  assign tri_done_count = done_q;
  assign tri_skip_count = skip_q;

  // Sequencer state, latched command, filler operands and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      tri_q   <= '0;
      fill_q  <= '0;
      guard_q <= 1'b0;
      done_q  <= '0;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      tri_q   <= tri_d;
      fill_q  <= fill_d;
      guard_q <= guard_d;
      done_q  <= done_d;
      skip_q  <= skip_d;
    end
  end

  // Next state: pop, sort or drop, launch, guarded wait, retire.
  always_comb begin
    state_d = state_q;
    tri_d   = tri_q;
    fill_d  = fill_q;
    guard_d = guard_q;
    done_d  = done_q;
    skip_d  = skip_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          tri_d   = head;
          state_d = S_SORT;
        end
      end
      S_SORT: begin
        if (sorted.v1.y == sorted.v3.y) begin
          skip_d  = skip_q + 16'd1;
          state_d = S_IDLE;
        end else begin
          fill_d  = sorted;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        guard_d = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // fill_done may still be high from the previous triangle.
        if (guard_q) begin
          guard_d = 1'b0;
        end else if (fill_done) begin
          state_d = S_RETIRE;
        end
      end
      S_RETIRE: begin
        done_d  = done_q + 16'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/triangle_sequencer.md
# triangle_sequencer

Command-side controller for the triangle filler. Accepts triangle commands from the host/geometry stage into a small queue, sorts each triangle's vertices by ascending y, launches the filler with a one-cycle start pulse and waits for its completion before issuing the next one. Triangles with zero height are dropped without occupying the filler. Sits between the command interface and the single shared `triangle_filler` instance.

## Interface
Parameters:
- `QUEUE_DEPTH`, 4: command queue entries; a power of two, ≥2.
- `COORD_W`, 9: coordinate width, matching the filler.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  queue can accept a command.
- `cmd_x1, cmd_y1, cmd_x2, cmd_y2, cmd_x3, cmd_y3`  in  COORD_W each  unsorted vertices.
- `fill_x1, fill_y1, fill_x2, fill_y2, fill_x3, fill_y3`  out  COORD_W each  sorted vertices to the filler; `fill_y1` ≤ `fill_y2` ≤ `fill_y3`.
- `fill_start`  out  1  one-cycle launch pulse to the filler.
- `fill_done`  in  1  filler completion; a level signal that stays high until the next start is consumed.
- `busy`  out  1  high when the queue is non-empty or the FSM is not in IDLE.
- `tri_done_count`  out  16  triangles completed by the filler; wraps modulo 2^16.
- `tri_skip_count`  out  16  degenerate triangles dropped; wraps modulo 2^16.

## Operation
- **Accept.** A command is accepted on a rising edge with `cmd_valid && cmd_ready`.
  - `cmd_ready = !full`.
  - Pop in the same cycle does not raise `cmd_ready`; there is no bypass.
  - `cmd_ready` is 0 while `reset` is high.
- **Queue.** FIFO with read/write pointers plus an occupancy count of `$clog2(QUEUE_DEPTH)+1` bits. Pointers wrap at `QUEUE_DEPTH`.
- **FSM states:** IDLE, SORT, LAUNCH, WAIT, RETIRE.
  - **IDLE → SORT:** when the queue is non-empty. The head entry is popped and latched.
  - **SORT → LAUNCH / IDLE:**
    - Apply a 3-element compare/swap network on y and register the sorted vertices to `fill_*`.
    - The sort is stable: equal y keep their command order (v1 before v2 before v3).
    - If sorted `y1 == y3`, the triangle is degenerate: increment `tri_skip_count`, leave `fill_*` unchanged and go to IDLE.
    - Otherwise go to LAUNCH.
  - **LAUNCH → WAIT:** `fill_start` = 1 for exactly this cycle.
  - **WAIT → RETIRE:**
    - The first WAIT cycle ignores `fill_done`, because a stale high level from the previous triangle may still be present.
    - From the second WAIT cycle onward, `fill_done` = 1 moves the FSM to RETIRE.
    - There is no timeout.
  - **RETIRE → IDLE:** increment `tri_done_count`.
- **Output stability.** `fill_*` coordinates hold stable from LAUNCH through RETIRE; the filler reads them throughout.
- **Reset.** Reset mid-operation empties the queue, returns the FSM to IDLE and drops any in-flight triangle. No count is incremented for it. The filler shares the same reset.
- **Reset values:**
  - `fill_*` coordinates: 0.
  - `fill_start`: 0.
  - `busy`: 0.
  - Both counters: 0.
  - `cmd_ready`: 0 during reset, 1 on the first cycle after.

## Timing
- **Launch latency.** With the FSM in IDLE and the queue empty, a command accepted at edge E0 produces `fill_start` high in the cycle after edge E2:
  - E1: pop, IDLE → SORT.
  - E2: SORT → LAUNCH.
- **Per-triangle overhead.** Excluding filler run time, each triangle costs 5 cycles: IDLE, SORT, LAUNCH, one guard WAIT cycle, RETIRE.
- **Degenerate triangle.** Costs 2 cycles (IDLE, SORT) and generates no `fill_start`.
- **Back-to-back.** The next triangle's pop occurs in the IDLE cycle following RETIRE.
- **`busy` timing.**
  - Rises the cycle after the first accepted command.
  - Falls the cycle after RETIRE or a skip, provided the queue is empty.

## Structure
- **Package `raster_pkg`:**
  - `coord_t` (logic [COORD_W-1:0]).
  - `vertex_t` struct {x, y}.
  - `triangle_t` struct of three `vertex_t`.
  - FSM enum `seq_state_t`.
  - Function `sort_by_y(triangle_t)` returning `triangle_t`; the stable network.
- **Sub-module `tri_cmd_fifo`:** parameterised by depth and entry type `triangle_t`. Ports: push, pop, full, empty, din, dout.
- **Top:** FSM, sort register, guard flag and counters.

## Test plan
- Single command (10,50),(100,5),(40,30) → `fill_start` 3 cycles after accept; `fill_*` = (100,5),(40,30),(10,50); `tri_done_count` = 1 two cycles after `fill_done` (RETIRE, then register).
- Tie (0,20),(8,20),(4,60) → stable order (0,20),(8,20),(4,60). Degenerate (1,7),(2,7),(3,7) → no `fill_start`; `tri_skip_count` = 1.
- Stale `fill_done` held high from before launch → ignored in the guard cycle. A fresh `fill_done` rising 10 cycles after `fill_start` → RETIRE on the following cycle.
- Push 5 commands with `cmd_valid` held high and filler stalled → `cmd_ready` = 0 after 4 queued plus 1 in flight. All 5 are later launched in order, with no loss or duplication.
- Assert `reset` in WAIT with 2 commands queued → the next cycle shows `busy` = 0, `fill_start` = 0, counters = 0, queue empty; `cmd_ready` = 1 one cycle after reset deasserts.
- Skip a degenerate triangle 65536 times → `tri_skip_count` wraps to 0.
